// File: rtl/pi_ratio_accumulator_pkg.sv
// Shared constants, divider state encoding and width helper for the pi estimator.
package pi_est_pkg;

  localparam int DEF_COORD_W = 9;
  localparam int DEF_RADIUS  = 480;
  localparam int DEF_CNT_W   = 20;
  localparam int DEF_FRAC_W  = 12;

  localparam int RADIUS_SQ = DEF_RADIUS * DEF_RADIUS;
  localparam int Q_W       = DEF_CNT_W + DEF_FRAC_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  function automatic int q_width(input int cnt_w, input int frac_w);
    return cnt_w + frac_w + 2;
  endfunction

endpackage

// File: rtl/pi_ratio_accumulator_if.sv
// Sample stream in, counters and pi estimate out; slave side is the accumulator.
interface pi_if #(
  parameter int COORD_W = 9,
  parameter int CNT_W   = 20,
  parameter int FRAC_W  = 12
);
  logic               sample_valid;
  logic [COORD_W-1:0] sample_x;
  logic [COORD_W-1:0] sample_y;
  logic               clear;
  logic [CNT_W-1:0]   inside_cnt;
  logic [CNT_W-1:0]   total_cnt;
  logic [FRAC_W+2:0]  pi_est;
  logic               pi_valid;
  logic               busy;
  logic               saturated;

  modport master (
    output sample_valid, sample_x, sample_y, clear,
    input  inside_cnt, total_cnt, pi_est, pi_valid, busy, saturated
  );

  modport slave (
    input  sample_valid, sample_x, sample_y, clear,
    output inside_cnt, total_cnt, pi_est, pi_valid, busy, saturated
  );
endinterface

// File: rtl/pi_ratio_accumulator_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W cycles per quotient.
// o_done is high during the cycle that produces the last bit; o_quotient is final after that edge.
module seq_divider #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quotient,
  output logic         o_done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic          w_ge;

  always_comb begin
    w_shift = {r_rem, r_quo[W-1]};
    w_diff  = w_shift - {1'b0, r_div};
    w_ge    = (w_shift >= {1'b0, r_div});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_abort) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= CW'(W);
      r_run <= 1'b1;
    end else if (r_run) begin
      // Remainder stays below the divisor, so it always fits back into W bits.
      r_rem <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
      r_quo <= {r_quo[W-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_run <= 1'b0;
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_run && (r_cnt == CW'(1));
endmodule

// File: rtl/pi_ratio_accumulator.sv
// Classifies LFSR samples against a quarter circle, counts them, and divides the counts
// into a Q3.FRAC_W estimate of pi; 3-stage sample pipeline, divider runs in the background.
module pi_ratio_accumulator
  import pi_est_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int RADIUS  = DEF_RADIUS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int FRAC_W  = DEF_FRAC_W
) (
  input  logic clk,
  input  logic reset_n,
  pi_if.slave  bus
);
  localparam int QW    = q_width(CNT_W, FRAC_W);
  localparam int SQ_W  = 2 * COORD_W;
  localparam int SUM_W = 2 * COORD_W + 1;
  localparam int PI_W  = FRAC_W + 3;
  localparam logic [COORD_W:0]   R_LIM    = (COORD_W + 1)'(RADIUS);
  localparam logic [SUM_W-1:0]   R_SQ     = SUM_W'(RADIUS * RADIUS);
  localparam logic [CNT_W-1:0]   CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [PI_W-1:0]    PI_MAX   = '1;

  logic               r_s1_vld, r_s1_acc;
  logic [COORD_W-1:0] r_s1_x, r_s1_y;
  logic               r_s2_vld;
  logic [SQ_W-1:0]    r_s2_xsq, r_s2_ysq;
  logic               r_s3_vld, r_s3_in;
  logic [CNT_W-1:0]   r_inside, r_total;
  logic               r_sat, r_pend, r_pi_vld;
  logic [PI_W-1:0]    r_pi;
  div_state_t         r_state, w_next;

  logic [SQ_W-1:0]    w_xsq, w_ysq;
  logic [SUM_W-1:0]   w_sum;
  logic               w_upd, w_start, w_busy, w_div_done, w_quo_hi;
  logic [QW-1:0]      w_quo;

  assign w_xsq    = SQ_W'(r_s1_x) * SQ_W'(r_s1_x);
  assign w_ysq    = SQ_W'(r_s1_y) * SQ_W'(r_s1_y);
  assign w_sum    = {1'b0, r_s2_xsq} + {1'b0, r_s2_ysq};
  assign w_upd    = r_s3_vld && !r_sat;
  assign w_quo_hi = |w_quo[QW-1:PI_W];

  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) begin
      r_s1_vld <= 1'b0;
      r_s1_acc <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s2_vld <= 1'b0;
      r_s2_xsq <= '0;
      r_s2_ysq <= '0;
      r_s3_vld <= 1'b0;
      r_s3_in  <= 1'b0;
      r_inside <= '0;
      r_total  <= '0;
      r_sat    <= 1'b0;
      r_pend   <= 1'b0;
      r_pi     <= '0;
      r_pi_vld <= 1'b0;
    end else begin
      r_s1_vld <= bus.sample_valid;
      r_s1_acc <= ({1'b0, bus.sample_x} < R_LIM) && ({1'b0, bus.sample_y} < R_LIM);
      r_s1_x   <= bus.sample_x;
      r_s1_y   <= bus.sample_y;
      r_s2_vld <= r_s1_vld && r_s1_acc;
      r_s2_xsq <= w_xsq;
      r_s2_ysq <= w_ysq;
      r_s3_vld <= r_s2_vld;
      r_s3_in  <= (w_sum < R_SQ);
      if (w_upd) begin
        r_total  <= r_total + CNT_W'(1);
        r_inside <= r_inside + CNT_W'(r_s3_in);
        if (r_total == CNT_LAST) r_sat <= 1'b1;
      end
      // An update landing in the LOAD cycle missed the snapshot, so it stays pending.
      if (r_state == ST_LOAD) r_pend <= w_upd;
      else if (w_upd)         r_pend <= 1'b1;
      if (r_state == ST_DONE) begin
        r_pi     <= w_quo_hi ? PI_MAX : w_quo[PI_W-1:0];
        r_pi_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) r_state <= ST_IDLE;
    else                       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE: if (r_pend && (r_total != '0)) w_next = ST_LOAD;
      ST_LOAD: begin
        w_start = 1'b1;
        w_busy  = 1'b1;
        w_next  = ST_DIV;
      end
      ST_DIV: begin
        w_busy = 1'b1;
        if (w_div_done) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  seq_divider #(.W(QW)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_start),
    .i_abort    (bus.clear),
    .i_dividend (QW'(r_inside) << (FRAC_W + 2)),
    .i_divisor  (QW'(r_total)),
    .o_quotient (w_quo),
    .o_done     (w_div_done)
  );

  assign bus.inside_cnt = r_inside;
  assign bus.total_cnt  = r_total;
  assign bus.pi_est     = r_pi;
  assign bus.pi_valid   = r_pi_vld;
  assign bus.busy       = w_busy;
  assign bus.saturated  = r_sat;
endmodule

// File: tb/tb_pi_ratio_accumulator.sv
// Directed bench: reset, single samples, boundary points, back-to-back stream, saturation and clear.
module tb_pi_ratio_accumulator;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pi_if #(.COORD_W(9), .CNT_W(20), .FRAC_W(12)) bus1 ();
  pi_if #(.COORD_W(9), .CNT_W(4),  .FRAC_W(12)) bus2 ();

  pi_ratio_accumulator #(.COORD_W(9), .RADIUS(480), .CNT_W(20), .FRAC_W(12)) u_dut (
    .clk (clk), .reset_n (reset_n), .bus (bus1)
  );

  pi_ratio_accumulator #(.COORD_W(9), .RADIUS(480), .CNT_W(4), .FRAC_W(12)) u_dut_sat (
    .clk (clk), .reset_n (reset_n), .bus (bus2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [8:0] x, input logic [8:0] y);
    bus1.sample_valid = 1'b1;
    bus1.sample_x     = x;
    bus1.sample_y     = y;
    @(negedge clk);
    bus1.sample_valid = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!bus1.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(bus1.busy), 64'd1);
  endtask

  logic [8:0] vx [8];
  logic [8:0] vy [8];

  initial begin
    int n;
    vx = '{9'd10, 9'd400, 9'd479, 9'd100, 9'd500, 9'd200, 9'd339, 9'd340};
    vy = '{9'd20, 9'd300, 9'd0,   9'd470, 9'd5,   9'd200, 9'd339, 9'd340};

    reset_n = 1'b0;
    bus1.sample_valid = 1'b1; bus1.sample_x = '0; bus1.sample_y = '0; bus1.clear = 1'b0;
    bus2.sample_valid = 1'b1; bus2.sample_x = '0; bus2.sample_y = '0; bus2.clear = 1'b0;
    cyc(2);
    check("rst_inside",   64'(bus1.inside_cnt), 64'd0);
    check("rst_total",    64'(bus1.total_cnt),  64'd0);
    check("rst_pi",       64'(bus1.pi_est),     64'd0);
    check("rst_pi_valid", 64'(bus1.pi_valid),   64'd0);
    check("rst_busy",     64'(bus1.busy),       64'd0);
    check("rst_sat",      64'(bus1.saturated),  64'd0);
    check("rst_total2",   64'(bus2.total_cnt),  64'd0);
    bus1.sample_valid = 1'b0;
    bus2.sample_valid = 1'b0;
    reset_n = 1'b1;
    cyc(6);
    check("idle_total", 64'(bus1.total_cnt), 64'd0);
    check("idle_busy",  64'(bus1.busy),      64'd0);

    // Single inside sample: latency, then 4.0
    push(9'd0, 9'd0);
    cyc(2);
    check("lat_total_early", 64'(bus1.total_cnt), 64'd0);
    cyc(1);
    check("s1_inside",   64'(bus1.inside_cnt), 64'd1);
    check("s1_total",    64'(bus1.total_cnt),  64'd1);
    check("s1_pi_vld_0", 64'(bus1.pi_valid),   64'd0);
    wait_busy("s1_busy");
    cyc(60);
    check("s1_pi",       64'(bus1.pi_est),   64'h4000);
    check("s1_pi_valid", 64'(bus1.pi_valid), 64'd1);
    check("s1_busy_end", 64'(bus1.busy),     64'd0);

    // Corner (479,479) is outside: 1/2 -> 2.0
    push(9'd479, 9'd479);
    cyc(3);
    check("s2_inside", 64'(bus1.inside_cnt), 64'd1);
    check("s2_total",  64'(bus1.total_cnt),  64'd2);
    wait_busy("s2_busy");
    check("s2_pi_hold", 64'(bus1.pi_est), 64'h4000);
    cyc(60);
    check("s2_pi", 64'(bus1.pi_est), 64'h2000);

    // Boundaries
    push(9'd480, 9'd0);
    cyc(4);
    check("rej_total", 64'(bus1.total_cnt), 64'd2);
    check("rej_busy",  64'(bus1.busy),      64'd0);
    push(9'd0, 9'd479);
    cyc(3);
    check("edge_in_inside", 64'(bus1.inside_cnt), 64'd2);
    check("edge_in_total",  64'(bus1.total_cnt),  64'd3);
    push(9'd288, 9'd384);
    cyc(3);
    check("exact_r_inside", 64'(bus1.inside_cnt), 64'd2);
    check("exact_r_total",  64'(bus1.total_cnt),  64'd4);
    cyc(100);
    check("bnd_pi", 64'(bus1.pi_est), 64'h2000);

    // Back-to-back stream overlapping a running division: 6/11 -> 98304/11
    for (int i = 0; i < 8; i++) begin
      bus1.sample_valid = 1'b1;
      bus1.sample_x     = vx[i];
      bus1.sample_y     = vy[i];
      @(negedge clk);
    end
    bus1.sample_valid = 1'b0;
    cyc(3);
    check("b2b_inside", 64'(bus1.inside_cnt), 64'd6);
    check("b2b_total",  64'(bus1.total_cnt),  64'd11);
    cyc(100);
    check("b2b_pi",       64'(bus1.pi_est),   64'd8936);
    check("b2b_pi_valid", 64'(bus1.pi_valid), 64'd1);
    check("b2b_busy_end", 64'(bus1.busy),     64'd0);

    // Saturation with 4-bit counters
    for (int i = 0; i < 15; i++) begin
      bus2.sample_valid = 1'b1;
      @(negedge clk);
    end
    bus2.sample_valid = 1'b0;
    cyc(3);
    check("sat_total",  64'(bus2.total_cnt),  64'd15);
    check("sat_inside", 64'(bus2.inside_cnt), 64'd15);
    check("sat_flag",   64'(bus2.saturated),  64'd1);
    bus2.sample_valid = 1'b1;
    @(negedge clk);
    bus2.sample_valid = 1'b0;
    cyc(3);
    check("sat_hold_total",  64'(bus2.total_cnt),  64'd15);
    check("sat_hold_inside", 64'(bus2.inside_cnt), 64'd15);

    n = 0;
    while (bus2.busy && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!bus2.busy && n < 100) begin @(negedge clk); n++; end
    cyc(3);
    check("sat_busy_mid",   64'(bus2.busy),     64'd1);
    check("sat_pi_vld_pre", 64'(bus2.pi_valid), 64'd1);
    bus2.clear        = 1'b1;
    bus2.sample_valid = 1'b1;
    @(negedge clk);
    bus2.clear        = 1'b0;
    bus2.sample_valid = 1'b0;
    check("clr_inside",   64'(bus2.inside_cnt), 64'd0);
    check("clr_total",    64'(bus2.total_cnt),  64'd0);
    check("clr_pi",       64'(bus2.pi_est),     64'd0);
    check("clr_pi_valid", 64'(bus2.pi_valid),   64'd0);
    check("clr_busy",     64'(bus2.busy),       64'd0);
    check("clr_sat",      64'(bus2.saturated),  64'd0);
    cyc(5);
    check("clr_drop_total", 64'(bus2.total_cnt), 64'd0);
    check("clr_busy_late",  64'(bus2.busy),      64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
